// File: rtl/attempt_checker.sv
// attempt_checker
// Screens the decrypted bytes of one key attempt. Each legal byte (space or
// lowercase letter) is accepted from the decrypt core and written to the
// decrypted-message RAM. The first illegal byte rejects the key. MSG_LEN
// legal bytes accept the key. Taking run low aborts or clears the attempt.
// ADDR_W is expected to be at most 7, because wr_addr is a slice of
// byte_count.
module attempt_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [6:0]        byte_count,
    output logic              failure,
    output logic              success
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FAIL,
        ST_PASS
    } state_t;

    localparam logic [6:0] LAST_COUNT = 7'(MSG_LEN);

    state_t            state_q, state_d;
    logic [6:0]        byte_count_q, byte_count_d;
    logic              failure_q, failure_d;
    logic              success_q, success_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    logic              byte_legal;
    logic              accept;
    logic [6:0]        count_inc;

    // Only the space character and 'a'..'z' can appear in a correct plaintext.
    assign byte_legal = (data_in == 8'h20) || ((data_in >= 8'h61) && (data_in <= 8'h7A));

    // The checker accepts a byte only while it is checking and the attempt is still live.
    // Run low therefore beats a coincident valid byte.
    assign data_ready = (state_q == ST_CHECK) && run;
    assign accept     = data_valid && data_ready;
    assign count_inc  = byte_count_q + 7'd1;

    // Next-state and registered-output logic for the attempt FSM.
    always_comb begin
        state_d      = state_q;
        byte_count_d = byte_count_q;
        failure_d    = failure_q;
        success_d    = success_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        if (!run) begin
            // Abort or clear. The RAM address and data simply hold, because
            // wr_en stays low.
            state_d      = ST_IDLE;
            byte_count_d = 7'd0;
            failure_d    = 1'b0;
            success_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A byte offered in this cycle is not accepted, because
                    // data_ready is still low.
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (accept) begin
                        if (byte_legal) begin
                            wr_en_d      = 1'b1;
                            wr_addr_d    = byte_count_q[ADDR_W-1:0];
                            wr_data_d    = data_in;
                            byte_count_d = count_inc;
                            if (count_inc == LAST_COUNT) begin
                                state_d   = ST_PASS;
                                success_d = 1'b1;
                            end
                        end else begin
                            state_d   = ST_FAIL;
                            failure_d = 1'b1;
                        end
                    end
                end
                default: begin
                    // FAIL and PASS hold until run drops.
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            byte_count_q <= 7'd0;
            failure_q    <= 1'b0;
            success_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            byte_count_q <= byte_count_d;
            failure_q    <= failure_d;
            success_q    <= success_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign byte_count = byte_count_q;
    assign failure    = failure_q;
    assign success    = success_q;

endmodule

// File: tb/tb_attempt_checker.sv
// Directed testbench for attempt_checker. A negedge monitor captures RAM
// writes, and the checks compare the DUT outputs against hand-computed
// values.
module tb_attempt_checker;

    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [7:0]        data_in;
    logic              data_valid;
    logic              data_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [6:0]        byte_count;
    logic              failure;
    logic              success;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] msg [MSG_LEN];
    logic [7:0] ram [MSG_LEN];
    bit         written [MSG_LEN];
    int         wr_cnt;
    int         dup_cnt;
    int         order_err;

    always #5 clk = ~clk;

    attempt_checker #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .byte_count (byte_count),
        .failure    (failure),
        .success    (success)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture RAM writes mid-cycle, and check that failure and success are never both high.
    always @(negedge clk) begin
        if (reset === 1'b1)
            check("excl", 32'(success & failure), 32'd0);
        if (wr_en === 1'b1) begin
            if (written[wr_addr]) dup_cnt++;
            if (int'(wr_addr) != wr_cnt) order_err++;
            written[wr_addr] = 1'b1;
            ram[wr_addr]     = wr_data;
            wr_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        for (int i = 0; i < MSG_LEN; i++) begin
            written[i] = 1'b0;
            ram[i]     = 8'h00;
        end
        wr_cnt    = 0;
        dup_cnt   = 0;
        order_err = 0;
    endtask

    // Offer a byte, wait (bounded) for data_ready, then pass the accepting edge.
    // data_valid is left high so that back-to-back calls stream continuously.
    task automatic send(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        for (int i = 0; i < 40 && data_ready !== 1'b1; i++) tick();
        if (data_ready !== 1'b1) check("ready_timeout", 32'(data_ready), 32'd1);
        tick();
    endtask

    task automatic send_gap(input logic [7:0] b, input int gap);
        data_valid = 1'b0;
        repeat (gap) tick();
        send(b);
    endtask

    task automatic new_attempt();
        data_valid = 1'b0;
        run        = 1'b0;
        tick();
        run = 1'b1;
        tick();
        clear_mon();
    endtask

    task automatic check_message(input string tag);
        check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd32);
        check({tag, "_dup"}, 32'(dup_cnt), 32'd0);
        check({tag, "_order"}, 32'(order_err), 32'd0);
        for (int i = 0; i < MSG_LEN; i++)
            check({tag, "_ram"}, 32'(ram[i]), 32'(msg[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bvec [6];
        bit         blegal [6];
        string      s;

        s = "the quick brown fox jumps over t";
        for (int i = 0; i < MSG_LEN; i++) msg[i] = s[i];
        bvec   = '{8'h20, 8'h61, 8'h7A, 8'h1F, 8'h60, 8'h7B};
        blegal = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        clear_mon();

        // Reset state
        reset      = 1'b0;
        run        = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;
        #1;
        check("rst_ready", 32'(data_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_count", 32'(byte_count), 32'd0);
        check("rst_fail", 32'(failure), 32'd0);
        check("rst_succ", 32'(success), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("idle_ready", 32'(data_ready), 32'd0);
        check("idle_wr_en", 32'(wr_en), 32'd0);

        // A byte offered in IDLE is ignored; the producer holds it until data_ready.
        run        = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'h63;
        #1;
        check("idle_run_ready", 32'(data_ready), 32'd0);
        tick();
        check("idle_byte_wr_en", 32'(wr_en), 32'd0);
        check("idle_byte_count", 32'(byte_count), 32'd0);
        check("check_ready", 32'(data_ready), 32'd1);
        tick();
        check("held_byte_wr_en", 32'(wr_en), 32'd1);
        check("held_byte_addr", 32'(wr_addr), 32'd0);
        check("held_byte_data", 32'(wr_data), 32'h63);
        data_valid = 1'b0;

        // Full legal message, data_valid continuous
        new_attempt();
        for (int i = 0; i < MSG_LEN; i++) begin
            send(msg[i]);
            if (i == MSG_LEN - 2) check("succ_early", 32'(success), 32'd0);
        end
        data_valid = 1'b0;
        check("pass_succ", 32'(success), 32'd1);
        check("pass_fail", 32'(failure), 32'd0);
        check("pass_count", 32'(byte_count), 32'd32);
        check("pass_ready", 32'(data_ready), 32'd0);
        check("pass_last_addr", 32'(wr_addr), 32'd31);
        tick();
        check("pass_wr_en_after", 32'(wr_en), 32'd0);
        check("pass_count_hold", 32'(byte_count), 32'd32);
        check_message("cont");

        // Illegal third byte
        new_attempt();
        send(8'h61);
        send(8'h62);
        send(8'h41);
        check("ill_fail", 32'(failure), 32'd1);
        check("ill_succ", 32'(success), 32'd0);
        check("ill_count", 32'(byte_count), 32'd2);
        check("ill_ready", 32'(data_ready), 32'd0);
        check("ill_wr_en", 32'(wr_en), 32'd0);
        data_in = 8'h61;
        tick();
        tick();
        data_valid = 1'b0;
        check("fail_hold", 32'(failure), 32'd1);
        check("fail_wr_en", 32'(wr_en), 32'd0);
        check("fail_count", 32'(byte_count), 32'd2);
        check("fail_writes", 32'(wr_cnt), 32'd2);

        // Drop run for one cycle: the attempt clears and restarts at address 0.
        run = 1'b0;
        tick();
        check("clr_fail", 32'(failure), 32'd0);
        check("clr_count", 32'(byte_count), 32'd0);
        run = 1'b1;
        tick();
        send(8'h7A);
        data_valid = 1'b0;
        check("restart_wr_en", 32'(wr_en), 32'd1);
        check("restart_addr", 32'(wr_addr), 32'd0);
        check("restart_data", 32'(wr_data), 32'h7A);
        check("restart_count", 32'(byte_count), 32'd1);

        // Boundary bytes, each in a fresh attempt
        for (int k = 0; k < 6; k++) begin
            new_attempt();
            send(bvec[k]);
            data_valid = 1'b0;
            check("bnd_fail", 32'(failure), 32'(!blegal[k]));
            check("bnd_wr_en", 32'(wr_en), 32'(blegal[k]));
            check("bnd_count", 32'(byte_count), 32'(blegal[k]));
        end

        // Full message with random gaps in data_valid
        new_attempt();
        for (int i = 0; i < MSG_LEN; i++) send_gap(msg[i], int'($urandom_range(0, 3)));
        data_valid = 1'b0;
        check("gap_succ", 32'(success), 32'd1);
        check("gap_fail", 32'(failure), 32'd0);
        tick();
        check_message("gap");

        // run low on the same edge as a valid byte: run wins.
        new_attempt();
        send(8'h61);
        data_in = 8'h62;
        run     = 1'b0;
        tick();
        check("abort_wr_en", 32'(wr_en), 32'd0);
        check("abort_count", 32'(byte_count), 32'd0);
        data_valid = 1'b0;
        tick();
        check("abort_writes", 32'(wr_cnt), 32'd1);

        // Asynchronous reset mid-attempt, after 10 accepted bytes
        new_attempt();
        for (int i = 0; i < 10; i++) send(msg[i]);
        data_valid = 1'b0;
        check("pre_rst_count", 32'(byte_count), 32'd10);
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", 32'(byte_count), 32'd0);
        check("arst_wr_en", 32'(wr_en), 32'd0);
        check("arst_addr", 32'(wr_addr), 32'd0);
        check("arst_data", 32'(wr_data), 32'd0);
        check("arst_fail", 32'(failure), 32'd0);
        check("arst_succ", 32'(success), 32'd0);
        check("arst_ready", 32'(data_ready), 32'd0);
        tick();
        reset = 1'b1;
        clear_mon();
        check("post_rst_ready", 32'(data_ready), 32'd0);
        tick();
        check("post_rst_ready2", 32'(data_ready), 32'd1);
        check("post_rst_wr_en", 32'(wr_en), 32'd0);
        send(8'h74);
        data_valid = 1'b0;
        check("post_rst_addr", 32'(wr_addr), 32'd0);
        check("post_rst_data", 32'(wr_data), 32'h74);
        check("post_rst_count", 32'(byte_count), 32'd1);
        tick();
        check("post_rst_writes", 32'(wr_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/attempt_checker.md
ATTEMPT_CHECKER -- requirements
Module: attempt_checker

Interface
REQ-001 Parameter MSG_LEN, default 32, number of decrypted bytes per attempt (2..64).
REQ-002 Parameter ADDR_W, default 5, width of wr_addr; 2**ADDR_W >= MSG_LEN.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low; clock clk.
REQ-005 run  input  1  attempt enable from key controller; low = abort/clear, high = attempt in progress.
REQ-006 data_in  input  8  decrypted byte from decrypt core.
REQ-007 data_valid  input  1  data_in valid this cycle.
REQ-008 data_ready  output  1  checker accepts a byte this cycle.
REQ-009 wr_en  output  1  one-cycle write strobe to decrypted-message RAM.
REQ-010 wr_addr  output  ADDR_W  RAM write address.
REQ-011 wr_data  output  8  RAM write data.
REQ-012 byte_count  output  7  legal bytes accepted in current attempt.
REQ-013 failure  output  1  current key rejected; level, held until run low.
REQ-014 success  output  1  current key accepted; level, held until run low or reset.

Function
REQ-015 States SHALL be IDLE, CHECK, FAIL, PASS; encoding free.
REQ-016 IDLE -> CHECK on the first rising edge with run=1.
REQ-017 Any state -> IDLE on any rising edge with run=0; byte_count, failure, success cleared on that same edge.
REQ-018 data_ready SHALL equal (state==CHECK) && run, combinationally; a byte is accepted on an edge where data_valid && data_ready.
REQ-019 Legal byte: data_in == 8'h20 or 8'h61 <= data_in <= 8'h7A; all other values illegal.
REQ-020 Accepted legal byte: wr_en=1, wr_addr=byte_count[ADDR_W-1:0], wr_data=data_in, all registered, valid the cycle after acceptance; byte_count increments on the accepting edge.
REQ-021 Accepted legal byte making byte_count == MSG_LEN: CHECK -> PASS; success=1 from the following cycle.
REQ-022 Accepted illegal byte: CHECK -> FAIL; no RAM write; byte_count unchanged; failure=1 from the following cycle.
REQ-023 wr_en SHALL be 0 in every cycle not following a legal acceptance; never two writes to the same address per attempt.
REQ-024 In FAIL and PASS, data_ready=0; data_valid ignored; state held until run=0.
REQ-025 failure and success SHALL never be 1 simultaneously.
REQ-026 run=0 on the same edge as data_valid: run wins, byte not accepted, no write issued.
REQ-027 byte_count SHALL never exceed MSG_LEN; no wrap.
REQ-028 data_valid with run=1 in IDLE (first cycle after run rises) SHALL be ignored; producer holds data until data_ready.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, byte_count=0, failure=0, success=0, wr_en=0, wr_addr=0, wr_data=0; data_ready=0 while reset low.
REQ-030 After reset release, block SHALL remain in IDLE until run=1 is sampled.
REQ-031 reset asserted mid-attempt SHALL discard progress; no further wr_en until a new attempt completes acceptance.

Verification
REQ-032 run rises, 32 bytes "the quick..." (all 0x20/0x61-0x7A), data_valid continuous -> 32 wr_en pulses addr 0..31, success=1 one cycle after 32nd acceptance, failure=0.
REQ-033 run high, bytes 0x61,0x62,0x41 -> two writes (addr 0,1), failure=1 cycle after 0x41 accepted, byte_count=2, data_ready=0 thereafter.
REQ-034 Boundary bytes 0x20,0x61,0x7A legal; 0x1F,0x60,0x7B each in fresh attempt -> failure.
REQ-035 failure held; drop run one cycle, raise again -> failure=0, byte_count=0, next byte written to addr 0.
REQ-036 Random data_valid gaps over 32 legal bytes -> identical RAM contents and success as REQ-032; run low coincident with valid byte -> no write.
REQ-037 reset pulsed low after 10 accepted bytes -> all outputs 0 immediately; attempt restarts at addr 0 after run sampled high.
